// File: rtl/jacobi_pkg.sv
// rtl/jacobi_pkg.sv - shared dimensions, state encoding and row slicing for the Jacobi eigen flow
package jacobi_pkg;
    localparam int N     = 32;
    localparam int W     = 32;
    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = $clog2(N * (N - 1) / 2 + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Column 0 sits in the MSBs of a packed row.
    function automatic int elem_msb(input int j);
        return N * W - 1 - W * j;
    endfunction
endpackage

// File: rtl/jacobi_pivot_search_if.sv
// rtl/jacobi_pivot_search_if.sv - row input and pivot result bundle (large_count under JACOBI_PIVOT_COUNT_EN)
interface jacobi_pivot_search_if;
    import jacobi_pkg::*;

    logic [N*W-1:0]   row_data;
    logic [IDX_W-1:0] row_index;
    logic             row_valid;
    logic             row_ready;
    logic [IDX_W-1:0] pivot_p;
    logic [IDX_W-1:0] pivot_q;
    logic [W-1:0]     pivot_val;
    logic             converged;
    logic             seq_error;
    logic             pivot_valid;
    logic             pivot_ready;
`ifdef JACOBI_PIVOT_COUNT_EN
    logic [CNT_W-1:0] large_count;
`endif

    modport slave (
        input  row_data, row_index, row_valid, pivot_ready,
        output row_ready, pivot_p, pivot_q, pivot_val, converged, seq_error, pivot_valid
`ifdef JACOBI_PIVOT_COUNT_EN
        , output large_count
`endif
    );

    modport master (
        output row_data, row_index, row_valid, pivot_ready,
        input  row_ready, pivot_p, pivot_q, pivot_val, converged, seq_error, pivot_valid
`ifdef JACOBI_PIVOT_COUNT_EN
        , input large_count
`endif
    );
endinterface

// File: rtl/jacobi_abs_sat.sv
// rtl/jacobi_abs_sat.sv - combinational saturating absolute value of a signed element
module jacobi_abs_sat
    import jacobi_pkg::*;
(
    input  logic [W-1:0] x,
    output logic [W-1:0] y
);
    always_comb begin
        y = x;
        if (x[W-1]) begin
            // The most negative value has no positive twin; clamp to the largest positive.
            if (x == {1'b1, {(W-1){1'b0}}})
                y = {1'b0, {(W-1){1'b1}}};
            else
                y = -x;
        end
    end
endmodule

// File: rtl/jacobi_pivot_search.sv
// rtl/jacobi_pivot_search.sv - largest off-diagonal pivot search over streamed rows (optional JACOBI_PIVOT_COUNT_EN)
module jacobi_pivot_search
    import jacobi_pkg::*;
#(
    parameter logic [W-1:0] THRESH = 32'd1
) (
    input  logic                 clk,
    input  logic                 reset,
    jacobi_pivot_search_if.slave bus
);
    state_t           state, state_next;
    logic [IDX_W-1:0] expected, cur_row, col;
    logic [N*W-1:0]   row_reg;
    logic [W-1:0]     elem, elem_abs;
    logic [W-1:0]     max_abs, max_val;
    logic [IDX_W-1:0] max_p, max_q;
    logic             seq_error;
    logic             row_accept, row_reject, last_row, last_col, cmp_en, take_new, handshake;

    assign row_accept = (state == IDLE) && bus.row_valid && (bus.row_index == expected);
    assign row_reject = (state == IDLE) && bus.row_valid && (bus.row_index != expected);
    assign last_row   = (cur_row == IDX_W'(N - 1));
    assign last_col   = last_row || (col == IDX_W'(N - 1));
    // The last row has no upper elements, so its single SCAN cycle never compares.
    assign cmp_en     = (state == SCAN) && !last_row;
    assign elem       = row_reg[elem_msb(int'(col)) -: W];
    assign take_new   = cmp_en && (elem_abs > max_abs);
    assign handshake  = (state == DONE) && bus.pivot_ready;

    jacobi_abs_sat u_abs (
        .x (elem),
        .y (elem_abs)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (row_accept) state_next = SCAN;
            SCAN: if (last_col)   state_next = last_row ? DONE : IDLE;
            DONE: if (bus.pivot_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            expected  <= '0;
            cur_row   <= '0;
            col       <= '0;
            row_reg   <= '0;
            max_abs   <= '0;
            max_val   <= '0;
            max_p     <= '0;
            max_q     <= IDX_W'(1);
            seq_error <= 1'b0;
        end else begin
            if (row_accept) begin
                row_reg <= bus.row_data;
                cur_row <= bus.row_index;
                col     <= bus.row_index + 1'b1;
            end
            if (row_reject)
                seq_error <= 1'b1;
            if (state == SCAN) begin
                col <= col + 1'b1;
                if (last_col && !last_row)
                    expected <= expected + 1'b1;
            end
            if (take_new) begin
                max_abs <= elem_abs;
                max_val <= elem;
                max_p   <= cur_row;
                max_q   <= col;
            end
            if (handshake) begin
                expected <= '0;
                max_abs  <= '0;
                max_val  <= '0;
                max_p    <= '0;
                max_q    <= IDX_W'(1);
            end
        end
    end

    // Result fields read as zero outside DONE so reset and idle present a clean bus.
    assign bus.row_ready   = (state == IDLE);
    assign bus.pivot_valid = (state == DONE);
    assign bus.pivot_p     = (state == DONE) ? max_p   : '0;
    assign bus.pivot_q     = (state == DONE) ? max_q   : '0;
    assign bus.pivot_val   = (state == DONE) ? max_val : '0;
    assign bus.converged   = (state == DONE) && (max_abs < THRESH);
    assign bus.seq_error   = seq_error;

`ifdef JACOBI_PIVOT_COUNT_EN
    logic [CNT_W-1:0] large_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            large_cnt <= '0;
        else if (handshake)
            large_cnt <= '0;
        else if (cmp_en && (elem_abs >= THRESH))
            large_cnt <= large_cnt + 1'b1;
    end

    assign bus.large_count = (state == DONE) ? large_cnt : '0;
`endif
endmodule

// File: tb/tb_jacobi_pivot_search.sv
// tb/tb_jacobi_pivot_search.sv - directed scoreboard bench for jacobi_pivot_search
module tb_jacobi_pivot_search;
    import jacobi_pkg::*;

    typedef struct {
        logic [IDX_W-1:0] p;
        logic [IDX_W-1:0] q;
        logic [W-1:0]     val;
        logic             conv;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;
    int   waited;
    exp_t exp_q[$];
    logic [W-1:0] mat [N][N];

    jacobi_pivot_search_if bus ();

    jacobi_pivot_search dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mat();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                mat[i][j] = '0;
    endtask

    task automatic set_sym(input int i, input int j, input logic [W-1:0] v);
        mat[i][j] = v;
        mat[j][i] = v;
    endtask

    task automatic push_exp(input int p, input int q, input logic [W-1:0] v, input bit conv, input int cnt);
        exp_t e;
        e.p    = IDX_W'(p);
        e.q    = IDX_W'(q);
        e.val  = v;
        e.conv = conv;
        e.cnt  = CNT_W'(cnt);
        exp_q.push_back(e);
    endtask

    task automatic send_row(input int r, input int idx);
        int n;
        @(negedge clk);
        for (int j = 0; j < N; j++)
            bus.row_data[N*W-1-W*j -: W] = mat[r][j];
        bus.row_index = IDX_W'(idx);
        bus.row_valid = 1'b1;
        n = 0;
        while (!bus.row_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_cmp++;
            n_bad++;
            $error("FAIL row_accept_%0d: row_ready observed 0, required 1", idx);
        end
        @(posedge clk);
        #1;
        bus.row_valid = 1'b0;
    endtask

    task automatic send_rows(input int first, input int last);
        for (int r = first; r <= last; r++)
            send_row(r, r);
    endtask

    task automatic get_result(input string tag, input bit ready_held, output int wcount);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (!bus.pivot_valid && n < 2000) begin
            @(negedge clk);
            n++;
        end
        wcount = n;
        check({tag, "_valid"}, 32'(bus.pivot_valid), 32'd1);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL %s_queue: observed empty scoreboard, required an entry", tag);
            return;
        end
        e = exp_q.pop_front();
        check({tag, "_p"},    32'(bus.pivot_p),   32'(e.p));
        check({tag, "_q"},    32'(bus.pivot_q),   32'(e.q));
        check({tag, "_val"},  bus.pivot_val,      e.val);
        check({tag, "_conv"}, 32'(bus.converged), 32'(e.conv));
`ifdef JACOBI_PIVOT_COUNT_EN
        check({tag, "_cnt"},  32'(bus.large_count), 32'(e.cnt));
`endif
        if (!ready_held) begin
            repeat (3) @(negedge clk);
            check({tag, "_hold_valid"}, 32'(bus.pivot_valid), 32'd1);
            check({tag, "_hold_p"},     32'(bus.pivot_p),     32'(e.p));
            check({tag, "_hold_val"},   bus.pivot_val,        e.val);
            bus.pivot_ready = 1'b1;
        end
        @(negedge clk);
        bus.pivot_ready = 1'b0;
        check({tag, "_drop_valid"}, 32'(bus.pivot_valid), 32'd0);
        check({tag, "_row_ready"},  32'(bus.row_ready),   32'd1);
    endtask

    initial begin
        clk = 1'b0;
        reset = 1'b1;
        n_cmp = 0;
        n_bad = 0;
        bus.row_data = '0;
        bus.row_index = '0;
        bus.row_valid = 1'b0;
        bus.pivot_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_row_ready",   32'(bus.row_ready),   32'd1);
        check("rst_pivot_valid", 32'(bus.pivot_valid), 32'd0);
        check("rst_converged",   32'(bus.converged),   32'd0);
        check("rst_seq_error",   32'(bus.seq_error),   32'd0);
        check("rst_pivot_q",     32'(bus.pivot_q),     32'd0);
        reset = 1'b0;

        // Identity matrix, consumer always ready.
        clear_mat();
        for (int i = 0; i < N; i++) mat[i][i] = 32'd1;
        push_exp(0, 1, 32'd0, 1'b1, 0);
        bus.pivot_ready = 1'b1;
        send_rows(0, N - 1);
        get_result("ident", 1'b1, waited);
        check("ident_latency", 32'(waited), 32'd1);

        // Negative pivot beats a slightly smaller positive.
        clear_mat();
        set_sym(3, 17, -32'sd500);
        set_sym(5, 9, 32'sd499);
        push_exp(3, 17, 32'hFFFFFE0C, 1'b0, 2);
        send_rows(0, N - 1);
        get_result("neg", 1'b0, waited);

        // Equal maxima: first scanned wins.
        clear_mat();
        set_sym(2, 30, 32'd1000);
        set_sym(10, 11, 32'd1000);
        push_exp(2, 30, 32'd1000, 1'b0, 2);
        send_rows(0, N - 1);
        get_result("tie", 1'b0, waited);

        // Saturated most-negative value ties with the max positive.
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                mat[i][j] = 32'h7FFFFFFF;
        set_sym(0, 31, 32'h80000000);
        push_exp(0, 1, 32'h7FFFFFFF, 1'b0, N * (N - 1) / 2);
        send_rows(0, N - 1);
        get_result("sat", 1'b0, waited);

        // Out-of-order row is dropped, then the sweep continues normally.
        clear_mat();
        set_sym(3, 17, -32'sd500);
        set_sym(5, 9, 32'sd499);
        push_exp(3, 17, 32'hFFFFFE0C, 1'b0, 2);
        send_row(0, 0);
        check("seq_before", 32'(bus.seq_error), 32'd0);
        send_row(2, 2);
        @(negedge clk);
        check("seq_set",       32'(bus.seq_error), 32'd1);
        check("seq_row_ready", 32'(bus.row_ready), 32'd1);
        send_rows(1, N - 1);
        get_result("seq", 1'b0, waited);
        check("seq_sticky", 32'(bus.seq_error), 32'd1);

        // Reset in the middle of row 7's scan abandons the sweep.
        send_rows(0, 7);
        repeat (5) @(negedge clk);
        check("mid_busy", 32'(bus.row_ready), 32'd0);
        reset = 1'b1;
        #1;
        check("mid_rst_row_ready", 32'(bus.row_ready),   32'd1);
        check("mid_rst_valid",     32'(bus.pivot_valid), 32'd0);
        check("mid_rst_seq_error", 32'(bus.seq_error),   32'd0);
        @(negedge clk);
        reset = 1'b0;
        push_exp(3, 17, 32'hFFFFFE0C, 1'b0, 2);
        send_rows(0, N - 1);
        get_result("post_rst", 1'b0, waited);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/jacobi_pivot_search.md
Name: jacobi_pivot_search

Overview:
- Downstream stage of the 32x32 matrix multiplier in the Jacobi eigen flow.
- Consumes the product matrix one 1024-bit row at a time.
- Scans the strict upper triangle for the off-diagonal element of largest magnitude.
- Presents pivot (p, q, value) and a convergence flag to the rotation-angle stage.

Parameters:
- N, 32, matrix dimension (rows and columns).
- W, 32, element width, signed two's complement.
- IDX_W, 5, index width, equal to clog2(N).
- THRESH, 32'd1, converged when max |a_pq| < THRESH (unsigned compare).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- row_data  input  N*W  row elements; element j at bits [N*W-1-W*j -: W] (column 0 in the MSBs).
- row_index  input  IDX_W  row number of row_data.
- row_valid  input  1  row_data/row_index valid.
- row_ready  output  1  block can accept a row this cycle.
- pivot_p  output  IDX_W  pivot row.
- pivot_q  output  IDX_W  pivot column (pivot_q > pivot_p).
- pivot_val  output  W  signed pivot element (not the absolute value).
- converged  output  1  max |off-diagonal| < THRESH.
- seq_error  output  1  sticky; out-of-order row seen.
- pivot_valid  output  1  result valid.
- pivot_ready  input  1  consumer accepts result.

Behaviour:
- Reset (async, immediate): state IDLE, expected row 0. All outputs 0 except row_ready=1. Running max cleared.
- Reset mid-scan or mid-DONE abandons the sweep. The first row after reset must be row 0.
- States:
  - IDLE: row_ready=1.
    - On row_valid with row_index == expected: latch row into local register, set col = row_index+1, go SCAN.
    - On row_valid with row_index != expected: row dropped, seq_error set (cleared only by reset), stay IDLE.
  - SCAN: row_ready=0. One column per cycle: compute abs_sat(elem[col]).
    - If strictly greater than running max, update max_abs, max_p=row, max_q=col, max_val=elem.
    - col increments. Leave SCAN after processing col=N-1.
    - Row N-1 has no upper elements: spends exactly 1 SCAN cycle with no compare.
    - After the last column: if row == N-1 go DONE, else expected++ and go IDLE.
    - Row r occupies max(N-1-r, 1) SCAN cycles. The next row is accepted the cycle after SCAN ends.
  - DONE: pivot_valid=1. Outputs are driven from registers, stable while pivot_valid=1 and pivot_ready=0.
    - converged = (max_abs < THRESH).
    - On pivot_ready: next cycle pivot_valid=0, running max cleared, expected=0, go IDLE.
    - row_ready=0 in DONE.
- abs_sat:
  - Negative x gives -x.
  - The most negative value (0x80000000) saturates to 0x7FFFFFFF.
- Ties: strict-greater update, so the first encountered wins (smallest p, then smallest q).
- Initial max is 0, idx (0,1), val 0. An all-zero off-diagonal yields p=0, q=1, val=0, converged=1.
- Lower triangle and diagonal are ignored (matrix is symmetric).
- row_valid while row_ready=0 is ignored. The source must hold row_valid until accepted.

Optional Feature:
- Macro: JACOBI_PIVOT_COUNT_EN.
- Defined: adds output large_count [clog2(N*(N-1)/2+1)-1:0], width 9 at N=32.
  - Counts scanned upper-triangle elements with abs_sat >= THRESH.
  - Valid with pivot_valid. Cleared on result handshake and on reset.
- Undefined: port and counter absent. Other behaviour is identical.

Decomposition:
- Shared package jacobi_pkg holds:
  - N, W, IDX_W.
  - The state enum (IDLE, SCAN, DONE).
  - An element-slice helper giving the bit offset of column j.
- Multiplier and rotation stages reuse the same package.
- One sub-module: jacobi_abs_sat (combinational W-bit saturating absolute value). Reused by the rotation stage.

Test Plan:
- Identity matrix, rows 0..31 in order, pivot_ready=1 -> pivot_valid after the last SCAN; p=0, q=1, val=0, converged=1.
- Zero matrix except a[3][17]=a[17][3]=-500 and a[5][9]=499 -> p=3, q=17, val=-500 (0xFFFFFE0C), converged=0.
- Two equal maxima 1000 at (2,30) and (10,11) -> p=2, q=30.
- Element 0x80000000 at (0,31), all others 0x7FFFFFFF -> max_abs tie at 0x7FFFFFFF; first scanned (0,1) wins.
- Send row 0, then row_index=2 -> seq_error=1, row dropped; row 1 still accepted next.
- Reset asserted during SCAN of row 7 -> outputs cleared immediately; a fresh 32-row sweep gives the correct pivot.
- JACOBI_PIVOT_COUNT_EN with THRESH=1 and the second scenario's matrix -> large_count=2.
